// File: rtl/led_pkg.sv
// Shared LED arbitration types: mode encoding, FSM state and an "active mode" helper.
package led_pkg;

   localparam int unsigned ModeW = 3;

   localparam logic [ModeW-1:0] LED_OFF  = 3'd0;
   localparam logic [ModeW-1:0] LED_ON   = 3'd1;
   localparam logic [ModeW-1:0] LED_SLOW = 3'd2;
   localparam logic [ModeW-1:0] LED_FAST = 3'd3;
   localparam logic [ModeW-1:0] LED_VARY = 3'd4;

   typedef enum logic [1:0] {
      StIdle,
      StHold,
      StOwn,
      StTest
   } led_state_e;

   // Codes 5..7 are reserved and behave exactly like off.
   function automatic logic mode_active(input logic [ModeW-1:0] m);
      return (m >= LED_ON) && (m <= LED_VARY);
   endfunction

endpackage

// File: rtl/led_prio_pick.sv
// Combinational finder for the lowest-index active request (valid and mode 1..4).
module led_prio_pick
   import led_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]       valid_i,
   input  logic [ModeW*NUM_REQ-1:0] mode_i,
   output logic                     found_o,
   output logic [2:0]               idx_o,
   output logic [ModeW-1:0]         mode_o
);

   // Scan from the top so the lowest active index is the last one written.
   always_comb begin
      found_o = 1'b0;
      idx_o   = 3'd0;
      mode_o  = LED_OFF;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (valid_i[i] && mode_active(mode_i[ModeW*i +: ModeW])) begin
            found_o = 1'b1;
            idx_o   = 3'(i);
            mode_o  = mode_i[ModeW*i +: ModeW];
         end
      end
   end

endmodule

// File: rtl/led_status_arbiter.sv
// Fixed-priority owner of one front-panel LED with a minimum display (hold) time.
// Define LED_TEST_EN to add a lamp-test phase (solid on) after every reset.
module led_status_arbiter
   import led_pkg::*;
#(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned HOLD_CYCLES = 12500000,
   parameter int unsigned TEST_CYCLES = 25000000
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [ModeW*NUM_REQ-1:0] req_mode,
   output logic                     on,
   output logic                     slow_flash,
   output logic                     fast_flash,
   output logic                     vary,
   output logic [2:0]               owner,
   output logic                     busy
);

   localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
   localparam logic [HoldW-1:0] HoldReload = HoldW'(HOLD_CYCLES - 1);

   if (HOLD_CYCLES < 2 || TEST_CYCLES < 1 || NUM_REQ < 2 || NUM_REQ > 8) begin : g_param_check
      $error("led_status_arbiter: illegal parameter value");
   end

   led_state_e       state_q, state_d;
   logic [2:0]       owner_q, owner_d;
   logic [ModeW-1:0] mode_q, mode_d;
   logic [HoldW-1:0] hold_q, hold_d;
   logic             on_q, on_d, slow_q, slow_d, fast_q, fast_d, vary_q, vary_d;
   logic             busy_q, busy_d;
   logic             do_grant, do_idle;

`ifdef LED_TEST_EN
   localparam int unsigned TestW = $clog2(TEST_CYCLES + 1);
   logic [TestW-1:0] test_q, test_d;
`endif

   logic             best_found;
   logic [2:0]       best_idx;
   logic [ModeW-1:0] best_mode;
   logic             own_valid, own_active;
   logic [ModeW-1:0] own_mode;

   led_prio_pick #(
      .NUM_REQ(NUM_REQ)
   ) u_pick (
      .valid_i(req_valid),
      .mode_i (req_mode),
      .found_o(best_found),
      .idx_o  (best_idx),
      .mode_o (best_mode)
   );

   always_comb begin
      own_valid = 1'b0;
      own_mode  = LED_OFF;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (owner_q == 3'(i)) begin
            own_valid = req_valid[i];
            own_mode  = req_mode[ModeW*i +: ModeW];
         end
      end
   end

   assign own_active = own_valid && mode_active(own_mode);

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      mode_d   = mode_q;
      hold_d   = hold_q;
      do_grant = 1'b0;
      do_idle  = 1'b0;
`ifdef LED_TEST_EN
      test_d   = test_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (best_found) do_grant = 1'b1;
         end
         StHold: begin
            if (hold_q != '0) hold_d = hold_q - HoldW'(1);
            // Preemption beats both expiry and the owner-drop stretch.
            if (best_found && (best_idx < owner_q)) begin
               do_grant = 1'b1;
            end else if (hold_q == '0) begin
               if (own_active) begin
                  state_d = StOwn;
                  mode_d  = own_mode;
               end else if (best_found) begin
                  do_grant = 1'b1;
               end else begin
                  do_idle = 1'b1;
               end
            end else if (own_active) begin
               mode_d = own_mode;
            end
         end
         StOwn: begin
            if (!best_found) begin
               do_idle = 1'b1;
            end else if (best_idx != owner_q) begin
               do_grant = 1'b1;
            end else begin
               mode_d = best_mode;
            end
         end
`ifdef LED_TEST_EN
         StTest: begin
            if (test_q == '0) do_idle = 1'b1;
            else              test_d  = test_q - TestW'(1);
         end
`endif
         default: do_idle = 1'b1;
      endcase

      if (do_grant) begin
         state_d = StHold;
         owner_d = best_idx;
         mode_d  = best_mode;
         hold_d  = HoldReload;
      end else if (do_idle) begin
         state_d = StIdle;
         owner_d = 3'd0;
         mode_d  = LED_OFF;
         hold_d  = '0;
      end

      on_d   = (state_d == StTest) || (mode_d == LED_ON);
      slow_d = (mode_d == LED_SLOW);
      fast_d = (mode_d == LED_FAST);
      vary_d = (mode_d == LED_VARY);
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
`ifdef LED_TEST_EN
         state_q <= StTest;
         test_q  <= TestW'(TEST_CYCLES);
`else
         state_q <= StIdle;
`endif
         owner_q <= 3'd0;
         mode_q  <= LED_OFF;
         hold_q  <= '0;
         on_q    <= 1'b0;
         slow_q  <= 1'b0;
         fast_q  <= 1'b0;
         vary_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
`ifdef LED_TEST_EN
         test_q  <= test_d;
`endif
         owner_q <= owner_d;
         mode_q  <= mode_d;
         hold_q  <= hold_d;
         on_q    <= on_d;
         slow_q  <= slow_d;
         fast_q  <= fast_d;
         vary_q  <= vary_d;
         busy_q  <= busy_d;
      end
   end

   assign on         = on_q;
   assign slow_flash = slow_q;
   assign fast_flash = fast_q;
   assign vary       = vary_q;
   assign owner      = owner_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_led_status_arbiter.sv
// Directed-vector bench for led_status_arbiter; a scoreboard queue holds the expected outputs.
module tb_led_status_arbiter;
   import led_pkg::*;

   localparam int unsigned NR    = 4;
   localparam int unsigned HOLD  = 8;
   localparam int unsigned TESTC = 5;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [11:0] req_mode = '0;
   logic        on, slow_flash, fast_flash, vary, busy;
   logic [2:0]  owner;

   typedef struct {
      logic [2:0] mode;
      logic [2:0] owner;
      logic       busy;
      string      name;
      int         idx;
   } exp_t;

   exp_t  sb[$];
   int    n_tests = 0;
   int    n_fail  = 0;
   int    vec_cnt = 0;
   string cur     = "init";

   led_status_arbiter #(
      .NUM_REQ    (NR),
      .HOLD_CYCLES(HOLD),
      .TEST_CYCLES(TESTC)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_mode  (req_mode),
      .on        (on),
      .slow_flash(slow_flash),
      .fast_flash(fast_flash),
      .vary      (vary),
      .owner     (owner),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   function automatic logic [11:0] pm(input logic [2:0] m0, input logic [2:0] m1,
                                      input logic [2:0] m2, input logic [2:0] m3);
      return {m3, m2, m1, m0};
   endfunction

   // {on, slow, fast, vary} expected for a mode code
   function automatic logic [3:0] cmd_of(input logic [2:0] m);
      case (m)
         3'd1:    return 4'b1000;
         3'd2:    return 4'b0100;
         3'd3:    return 4'b0010;
         3'd4:    return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   // Drive one vector; expectation is for outputs right after the edge that samples it.
   task automatic step(input logic rst, input logic [3:0] v, input logic [11:0] m,
                       input logic [2:0] em, input logic [2:0] eo, input logic eb);
      exp_t e;
      @(negedge clock);
      reset     = rst;
      req_valid = v;
      req_mode  = m;
      e.mode  = em;
      e.owner = eo;
      e.busy  = eb;
      e.name  = cur;
      e.idx   = vec_cnt;
      vec_cnt++;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      cur = "reset";
      repeat (3) step(1'b1, 4'h0, 12'h0, LED_OFF, 3'd0, 1'b0);
`ifdef LED_TEST_EN
      cur = "lamp_test";
      repeat (2) step(1'b0, 4'hf, pm(1, 1, 1, 1), LED_ON, 3'd0, 1'b1);
      step(1'b1, 4'hf, pm(1, 1, 1, 1), LED_OFF, 3'd0, 1'b0);
      repeat (TESTC) step(1'b0, 4'hf, pm(1, 1, 1, 1), LED_ON, 3'd0, 1'b1);
      step(1'b0, 4'hf, pm(2, 2, 2, 2), LED_OFF, 3'd0, 1'b0);
      step(1'b0, 4'hf, pm(2, 2, 2, 2), LED_SLOW, 3'd0, 1'b1);
      step(1'b1, 4'h0, 12'h0, LED_OFF, 3'd0, 1'b0);
      repeat (TESTC) step(1'b0, 4'h0, 12'h0, LED_ON, 3'd0, 1'b1);
      step(1'b0, 4'h0, 12'h0, LED_OFF, 3'd0, 1'b0);
`endif
   endtask

   // Monitor: outputs are compared every cycle an expectation is pending.
   always @(posedge clock) begin
      exp_t       e;
      logic [3:0] act;
      #1;
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         act = {on, slow_flash, fast_flash, vary};
         n_tests++;
         if (act !== cmd_of(e.mode) || owner !== e.owner || busy !== e.busy) begin
            n_fail++;
            $display("FAIL %s vec%0d: got cmd=%b owner=%0d busy=%b, want cmd=%b owner=%0d busy=%b",
                     e.name, e.idx, act, owner, busy, cmd_of(e.mode), e.owner, e.busy);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached, got running, want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      cur = "t1_grant_slow";
      step(1'b0, 4'b0100, pm(0, 0, 2, 0), LED_SLOW, 3'd2, 1'b1);
      repeat (7) step(1'b0, 4'b0000, 12'h0, LED_SLOW, 3'd2, 1'b1);
      step(1'b0, 4'b0000, 12'h0, LED_OFF, 3'd0, 1'b0);

      cur = "t2_pulse_hold";
      step(1'b0, 4'b1000, pm(0, 0, 0, 1), LED_ON, 3'd3, 1'b1);
      repeat (7) step(1'b0, 4'b0000, 12'h0, LED_ON, 3'd3, 1'b1);
      step(1'b0, 4'b0000, 12'h0, LED_OFF, 3'd0, 1'b0);

      cur = "t3_preempt";
      repeat (4) step(1'b0, 4'b1000, pm(0, 0, 0, 3), LED_FAST, 3'd3, 1'b1);
      step(1'b0, 4'b1001, pm(4, 0, 0, 3), LED_VARY, 3'd0, 1'b1);
      repeat (7) step(1'b0, 4'b1000, pm(0, 0, 0, 3), LED_VARY, 3'd0, 1'b1);
      cur = "t3_regrant_own";
      repeat (10) step(1'b0, 4'b1000, pm(0, 0, 0, 3), LED_FAST, 3'd3, 1'b1);
      step(1'b0, 4'b0000, 12'h0, LED_OFF, 3'd0, 1'b0);

      cur = "t4_low_prio_wait";
      repeat (3) step(1'b0, 4'b0011, pm(5, 1, 0, 0), LED_ON, 3'd1, 1'b1);
      repeat (7) step(1'b0, 4'b0111, pm(5, 1, 2, 0), LED_ON, 3'd1, 1'b1);
      step(1'b0, 4'b0101, pm(5, 1, 2, 0), LED_SLOW, 3'd2, 1'b1);
      repeat (7) step(1'b0, 4'b0001, pm(5, 0, 0, 0), LED_SLOW, 3'd2, 1'b1);
      step(1'b0, 4'b0001, pm(5, 0, 0, 0), LED_OFF, 3'd0, 1'b0);

      cur = "t5_live_mode";
      repeat (2) step(1'b0, 4'b0010, pm(0, 2, 0, 0), LED_SLOW, 3'd1, 1'b1);
      repeat (6) step(1'b0, 4'b0010, pm(0, 3, 0, 0), LED_FAST, 3'd1, 1'b1);
      step(1'b0, 4'b0000, 12'h0, LED_OFF, 3'd0, 1'b0);

      cur = "t6_drop_and_preempt";
      step(1'b0, 4'b0100, pm(0, 0, 1, 0), LED_ON, 3'd2, 1'b1);
      step(1'b0, 4'b0010, pm(0, 4, 0, 0), LED_VARY, 3'd1, 1'b1);
      repeat (7) step(1'b0, 4'b0000, 12'h0, LED_VARY, 3'd1, 1'b1);
      step(1'b0, 4'b0000, 12'h0, LED_OFF, 3'd0, 1'b0);

      cur = "t7_reset_abort";
      step(1'b0, 4'b1000, pm(0, 0, 0, 3), LED_FAST, 3'd3, 1'b1);
      step(1'b1, 4'b1000, pm(0, 0, 0, 3), LED_OFF, 3'd0, 1'b0);
`ifdef LED_TEST_EN
      repeat (TESTC) step(1'b0, 4'b0000, 12'h0, LED_ON, 3'd0, 1'b1);
`endif
      step(1'b0, 4'b0000, 12'h0, LED_OFF, 3'd0, 1'b0);
      step(1'b0, 4'b0000, 12'h0, LED_OFF, 3'd0, 1'b0);

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
      #2;
      if (sb.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/led_status_arbiter.md
Name: led_status_arbiter

Overview:
- Shares one front-panel LED between NUM_REQ status sources, such as link, PLL lock, TX and overload.
- Picks one owner by fixed priority, with index 0 highest. Drives the on / slow_flash / fast_flash / vary command lines of the downstream LED flasher.
- Enforces a minimum display (hold) time so short events stay visible. Higher-priority sources may still preempt immediately.
- Sits between status logic and the LED flasher instance, one arbiter per LED.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 12500000, minimum display time in clock cycles (0.5 s at 25 MHz); must be ≥ 2.
- TEST_CYCLES, 25000000, lamp-test duration after reset; used only with LED_TEST_EN.

Ports:
- clock  in  1  system clock (25 MHz nominal).
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-source request; bit i belongs to source i.
- req_mode  in  3*NUM_REQ  per-source mode, bits [3i+2:3i]: 0 = off, 1 = on, 2 = slow, 3 = fast, 4 = vary, 5..7 = treated as off.
- on  out  1  command to flasher: solid on.
- slow_flash  out  1  command: slow flash.
- fast_flash  out  1  command: fast flash.
- vary  out  1  command: vary pattern.
- owner  out  3  index of the current owner; 0 when idle.
- busy  out  1  high when any source owns the LED.

Behaviour:
- Definitions:
  - A request is "active" when req_valid[i]=1 and its mode is 1..4.
  - "best" is the lowest-index active request.
- All outputs are registered. A grant decided on cycle n is visible on the outputs at cycle n+1.
- At most one of on/slow_flash/fast_flash/vary is high at any time. All low means LED off.
- Reset:
  - on, slow_flash, fast_flash, vary, busy and owner are all 0.
  - State goes to IDLE and hold_cnt is 0.
  - Reset asserted mid-HOLD or mid-OWN aborts immediately; no stretch is applied.
- States:
  - IDLE: if best exists, latch owner=best and mode=best's mode, load hold_cnt=HOLD_CYCLES-1, and go to HOLD. Otherwise all commands stay 0.
  - HOLD:
    - Counts down: hold_cnt decrements by 1 each cycle.
    - If a request with index < owner is active: preempt. Owner and mode take the new source, hold_cnt reloads, state stays HOLD.
    - Else, if the owner is still active: mode tracks the owner's current req_mode live, with no reload.
    - Else (owner dropped): the last mode is frozen; this is the stretch.
    - When hold_cnt==0: go to OWN if the owner is still active, else re-arbitrate as in IDLE in that same cycle (grant best, or go to IDLE).
  - OWN:
    - Re-arbitrates every cycle.
    - If best != owner (higher priority arrived, or owner dropped and another source is active): switch to best, reload hold_cnt, go to HOLD.
    - If no request is active: go to IDLE, commands 0.
    - Owner mode changes track live.
- Lower-priority requests never preempt. They are served only after the owner releases and the hold has expired.
- Simultaneous owner drop and higher-priority arrival in HOLD: preemption wins.
- busy = (state != IDLE), registered with the outputs.
- hold_cnt width is $clog2(HOLD_CYCLES). Reload value is HOLD_CYCLES-1, so one grant holds exactly HOLD_CYCLES output cycles.

Optional Feature:
- Macro: LED_TEST_EN.
- With the macro defined:
  - After reset release, the block enters state TEST for TEST_CYCLES cycles, with on=1, busy=1, owner=0.
  - Requests are ignored during TEST, then the block goes to IDLE.
  - Reset during TEST restarts the test.
- Without the macro: there is no TEST state, and the block goes to IDLE directly after reset.

Decomposition:
- Shared package led_pkg holds:
  - the mode encoding constants (LED_OFF=0, LED_ON=1, LED_SLOW=2, LED_FAST=3, LED_VARY=4);
  - the state typedef (IDLE, HOLD, OWN, TEST);
  - the 3-bit mode width.
- One natural sub-module, led_prio_pick: combinational lowest-index active-request finder that outputs a found flag, index and mode. It is reused by the flasher-bank wrapper.

Test Plan (HOLD_CYCLES=8, TEST_CYCLES=5, NUM_REQ=4):
1. Reset for 3 cycles, then req 2 valid with mode 2 → slow_flash=1 and owner=2 on the cycle after the request, busy=1; all outputs 0 during reset.
2. Req 3 with mode 1 pulsed for 1 cycle → on=1 for exactly 8 cycles, then all commands 0 and busy=0.
3. Req 3 with mode 3 holding for 4 cycles, then req 0 with mode 4 → vary=1 and owner=0 on the next cycle (preemption); after req 0 drops, vary is held 8 cycles total, then owner=3, fast_flash=1.
4. Req 1 held from t0 for 10 cycles, req 2 asserted at t0+3 → req 2 ignored while req 1 is active; owner switches to 2 on the cycle after req 1 drops.
5. Owner req 1 changes mode 2→3 mid-HOLD → outputs switch slow_flash→fast_flash one cycle later; hold_cnt is not reloaded.
6. LED_TEST_EN defined: after reset, on=1 for 5 cycles regardless of req_valid=4'b1111; reset asserted at cycle 2 restarts the 5-cycle test; then normal arbitration, owner=0.
